ocram_bist_master: RTL and testbench

- Avalon-MM master that drives the 256x32 on-chip RAM slave directly: fills every word with a selected pattern, reads every word back, and compares the data against the expected pattern.
- Sits upstream of the on-chip RAM in the Qsys test system, connected point-to-point to its s1 port.
- Reports busy, done, error count and first-failure capture to a control/status PIO.

---
 rtl/ocram_bist_master.sv | 220 ++++++++++++++++++++++
 tb/tb_ocram_bist_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ocram_bist_master.sv
// Avalon-MM BIST master for a point-to-point 256x32 on-chip RAM: fills every word
// with a selected pattern, reads it back and records mismatch count and first failure.
module ocram_bist_master #(
    parameter int unsigned       ADDR_W       = 8,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       READ_LATENCY = 1,
    parameter logic [DATA_W-1:0] SEED         = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] pattern_in,
    input  logic [DATA_W-1:0] seed_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_rdata,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata
);
    // Right-shift Galois form of polynomial 0x80200003; the x^0 term is the shifted-out bit.
    localparam logic [DATA_W-1:0] LFSR_TAPS = 32'h8020_0002;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] const_q;
    logic [DATA_W-1:0] seed_q;
    logic [DATA_W-1:0] lfsr_q;
    logic [DATA_W-1:0] pat_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        drain_q;
    logic              busy_q;
    logic              done_q;
    logic              cs_q;
    logic              wr_q;
    logic              error_q;
    logic [ADDR_W:0]   err_cnt_q;
    logic [ADDR_W-1:0] faddr_q;
    logic [DATA_W-1:0] frdata_q;

    logic              pipe_vld_q  [READ_LATENCY];
    logic [ADDR_W-1:0] pipe_addr_q [READ_LATENCY];
    logic [DATA_W-1:0] pipe_exp_q  [READ_LATENCY];

    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] lfsr_d;
    logic [DATA_W-1:0] pat_d;
    logic [DATA_W-1:0] seed_sel;
    logic              cmp_bad;

    function automatic logic [DATA_W-1:0] pattern_of(
        input logic [1:0]        m,
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] lfsr,
        input logic [DATA_W-1:0] k
    );
        logic [DATA_W-1:0] w;
        case (m)
            2'd0:    w = DATA_W'(a);
            2'd1:    w = ~DATA_W'(a);
            2'd2:    w = lfsr;
            default: w = k;
        endcase
        return w;
    endfunction

    always_comb begin
        addr_d   = addr_q + ADDR_W'(1);
        lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        pat_d    = pattern_of(mode_q, addr_d, lfsr_d, const_q);
        seed_sel = (seed_in == '0) ? SEED : seed_in;
        cmp_bad  = pipe_vld_q[READ_LATENCY-1] &&
                   (m_readdata != pipe_exp_q[READ_LATENCY-1]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            const_q   <= '0;
            seed_q    <= '0;
            lfsr_q    <= '0;
            pat_q     <= '0;
            addr_q    <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            faddr_q   <= '0;
            frdata_q  <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= 1'b0;
            end
        end else if (abort) begin
            // Abort drops in-flight compares; results keep their partial values.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;

            pipe_vld_q[0]  <= (state_q == S_READ);
            pipe_addr_q[0] <= addr_q;
            pipe_exp_q[0]  <= pat_q;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
                pipe_exp_q[i]  <= pipe_exp_q[i-1];
            end

            if (cmp_bad) begin
                err_cnt_q <= err_cnt_q + (ADDR_W+1)'(1);
                error_q   <= 1'b1;
                if (err_cnt_q == '0) begin
                    faddr_q  <= pipe_addr_q[READ_LATENCY-1];
                    frdata_q <= m_readdata;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        const_q   <= pattern_in;
                        seed_q    <= seed_sel;
                        lfsr_q    <= seed_sel;
                        pat_q     <= pattern_of(mode, '0, seed_sel, pattern_in);
                        addr_q    <= '0;
                        err_cnt_q <= '0;
                        error_q   <= 1'b0;
                        faddr_q   <= '0;
                        frdata_q  <= '0;
                        busy_q    <= 1'b1;
                        cs_q      <= 1'b1;
                        wr_q      <= 1'b1;
                        state_q   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (addr_q == '1) begin
                        addr_q  <= '0;
                        lfsr_q  <= seed_q;
                        pat_q   <= pattern_of(mode_q, '0, seed_q, const_q);
                        wr_q    <= 1'b0;
                        state_q <= S_READ;
                    end else begin
                        addr_q <= addr_d;
                        lfsr_q <= lfsr_d;
                        pat_q  <= pat_d;
                    end
                end
                S_READ: begin
                    if (addr_q == '1) begin
                        cs_q    <= 1'b0;
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q <= addr_d;
                        lfsr_q <= lfsr_d;
                        pat_q  <= pat_d;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == 2'(READ_LATENCY - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign err_count       = err_cnt_q;
    assign first_err_addr  = faddr_q;
    assign first_err_rdata = frdata_q;
    assign m_address       = addr_q;
    assign m_byteenable    = 4'hF;
    assign m_chipselect    = cs_q;
    assign m_write         = wr_q;
    assign m_writedata     = pat_q;
    assign m_clken         = 1'b1;

endmodule

// File: tb/tb_ocram_bist_master.sv
// Bench for ocram_bist_master: two instances (read latency 1 and 2) share stimulus,
// each talks to its own RAM model with optional stuck-at-0 bits; results vs a pattern model.
module tb_ocram_bist_master;
    logic        clk = 1'b0;
    logic        reset_n, start, abort;
    logic [1:0]  mode;
    logic [31:0] pattern_in, seed_in;

    logic        busy1, done1, error1, cs1, wr1, clken1;
    logic [8:0]  ecnt1;
    logic [7:0]  faddr1, adr1;
    logic [31:0] frd1, wdat1, rd1;
    logic [3:0]  be1;
    logic        busy2, done2, error2, cs2, wr2, clken2;
    logic [8:0]  ecnt2;
    logic [7:0]  faddr2, adr2;
    logic [31:0] frd2, wdat2, rd2a, rd2b;
    logic [3:0]  be2;

    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];
    logic [31:0] stuck [256];
    logic [31:0] exp_tbl [256];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int wadr1[$], wcyc1[$], radr1[$], dcyc1[$];
    int wadr2[$], radr2[$], dcyc2[$];
    logic [31:0] wdq1[$], wdq2[$];

    always #5 clk = ~clk;

    ocram_bist_master #(.READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
        .pattern_in(pattern_in), .seed_in(seed_in), .busy(busy1), .done(done1),
        .error(error1), .err_count(ecnt1), .first_err_addr(faddr1),
        .first_err_rdata(frd1), .m_address(adr1), .m_byteenable(be1),
        .m_chipselect(cs1), .m_write(wr1), .m_writedata(wdat1), .m_clken(clken1),
        .m_readdata(rd1)
    );

    ocram_bist_master #(.READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
        .pattern_in(pattern_in), .seed_in(seed_in), .busy(busy2), .done(done2),
        .error(error2), .err_count(ecnt2), .first_err_addr(faddr2),
        .first_err_rdata(frd2), .m_address(adr2), .m_byteenable(be2),
        .m_chipselect(cs2), .m_write(wr2), .m_writedata(wdat2), .m_clken(clken2),
        .m_readdata(rd2b)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cs1 && wr1) mem1[adr1] <= wdat1 & ~stuck[adr1];
        rd1 <= mem1[adr1];
        if (cs2 && wr2) mem2[adr2] <= wdat2 & ~stuck[adr2];
        rd2a <= mem2[adr2];
        rd2b <= rd2a;
    end

    always @(negedge clk) begin
        if (cs1 && wr1) begin wadr1.push_back(int'(adr1)); wdq1.push_back(wdat1); wcyc1.push_back(cyc); end
        if (cs1 && !wr1) radr1.push_back(int'(adr1));
        if (done1) dcyc1.push_back(cyc);
        if (cs2 && wr2) begin wadr2.push_back(int'(adr2)); wdq2.push_back(wdat2); end
        if (cs2 && !wr2) radr2.push_back(int'(adr2));
        if (done2) dcyc2.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0002) : (s >> 1);
    endfunction

    task automatic clear_faults();
        for (int a = 0; a < 256; a++) stuck[a] = '0;
    endtask

    // Compares one run's bus log against exp_tbl: in-order writes, then in-order reads.
    task automatic check_bus(input string tag, input int wa[$], input logic [31:0] wd[$],
                             input int ra[$], input int w0, input int r0);
        int nbad = 0;
        check({tag, "_nwr"}, 64'(wa.size() - w0), 256);
        check({tag, "_nrd"}, 64'(ra.size() - r0), 256);
        for (int i = 0; i < 256; i++) begin
            if (w0 + i >= wa.size() || wa[w0+i] != i || wd[w0+i] != exp_tbl[i]) nbad++;
            if (r0 + i >= ra.size() || ra[r0+i] != i) nbad++;
        end
        check({tag, "_buslog"}, 64'(nbad), 0);
    endtask

    task automatic run(input string nm, input int md, input logic [31:0] k,
                       input logic [31:0] sd, input bit mid_start, output int w0o);
        int w01, w02, r01, r02, d01, d02, t0, n, nerr, fa, g;
        logic [31:0] s, frd;
        s = (sd == 0) ? 32'h1 : sd;
        nerr = 0; fa = 0; frd = '0;
        for (int a = 0; a < 256; a++) begin
            case (md)
                0: exp_tbl[a] = 32'(a);
                1: exp_tbl[a] = ~32'(a);
                2: begin exp_tbl[a] = s; s = lfsr_next(s); end
                default: exp_tbl[a] = k;
            endcase
            if ((exp_tbl[a] & stuck[a]) != 0) begin
                if (nerr == 0) begin fa = a; frd = exp_tbl[a] & ~stuck[a]; end
                nerr++;
            end
        end
        w01 = wadr1.size(); w02 = wadr2.size(); r01 = radr1.size(); r02 = radr2.size();
        d01 = dcyc1.size(); d02 = dcyc2.size();
        w0o = w01;

        @(posedge clk); #1;
        mode = md[1:0]; pattern_in = k; seed_in = sd; start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 2'($urandom); pattern_in = $urandom; seed_in = $urandom;
        check({nm, "_clr_cnt"}, 64'(ecnt1), 0);
        check({nm, "_clr_err"}, 64'(error1), 0);
        check({nm, "_busy"}, 64'({busy1, cs1, wr1, busy2}), 64'hF);

        if (mid_start) begin
            while (cyc < t0 + 90) @(posedge clk);
            #1 start = 1'b1; mode = 2'd3;
            @(posedge clk); #1 start = 1'b0;
        end

        n = 0;
        while ((dcyc1.size() == d01 || dcyc2.size() == d02) && n < 800) begin
            @(posedge clk); n++;
        end
        repeat (4) @(negedge clk);
        check({nm, "_ndone1"}, 64'(dcyc1.size() - d01), 1);
        check({nm, "_ndone2"}, 64'(dcyc2.size() - d02), 1);
        g = (dcyc1.size() > d01) ? dcyc1[d01] : -1;
        check({nm, "_done1_cyc"}, 64'(g), 64'(t0 + 514));
        g = (dcyc2.size() > d02) ? dcyc2[d02] : -1;
        check({nm, "_done2_cyc"}, 64'(g), 64'(t0 + 515));
        g = (wcyc1.size() > w01) ? wcyc1[w01] : -1;
        check({nm, "_first_wr_cyc"}, 64'(g), 64'(t0 + 1));

        check({nm, "_busy_after"}, 64'({busy1, busy2, cs1, cs2}), 0);
        check({nm, "_ecnt1"}, 64'(ecnt1), 64'(nerr));
        check({nm, "_ecnt2"}, 64'(ecnt2), 64'(nerr));
        check({nm, "_error1"}, 64'(error1), 64'(nerr != 0));
        check({nm, "_error2"}, 64'(error2), 64'(nerr != 0));
        check({nm, "_faddr1"}, 64'(faddr1), 64'(fa));
        check({nm, "_faddr2"}, 64'(faddr2), 64'(fa));
        check({nm, "_frd1"}, 64'(frd1), 64'(frd));
        check({nm, "_frd2"}, 64'(frd2), 64'(frd));
        check_bus({nm, "_d1"}, wadr1, wdq1, radr1, w01, r01);
        check_bus({nm, "_d2"}, wadr2, wdq2, radr2, w02, r02);
    endtask

    initial begin
        int w0, n, d01, d02, nf, fa;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        mode = '0; pattern_in = '0; seed_in = '0;
        clear_faults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl1", 64'({busy1, done1, error1, cs1, wr1}), 0);
        check("rst_res1", 64'({ecnt1, faddr1, frd1}), 0);
        check("rst_bus1", 64'({adr1, wdat1}), 0);
        check("rst_const1", 64'({clken1, be1}), 64'h1F);
        check("rst_ctl2", 64'({busy2, done2, error2, cs2, wr2, ecnt2}), 0);
        #1 reset_n = 1'b1;
        while (cyc < 9) begin @(posedge clk); #1; end

        run("m0", 0, '0, '0, 1'b0, w0);

        run("m2s0", 2, '0, '0, 1'b0, w0);
        check("m2s0_w0", 64'(wdq1[w0]), 64'h1);
        check("m2s0_w1", 64'(wdq1[w0+1]), 64'h8020_0002);

        stuck[5] = 32'h4; stuck[200] = 32'h4;
        run("m3flt", 3, 32'hA5A5_A5A5, '0, 1'b0, w0);
        check("m3flt_cnt", 64'(ecnt1), 2);
        check("m3flt_frd", 64'(frd1), 64'hA5A5_A5A1);
        clear_faults();

        run("m1rerun", 1, '0, '0, 1'b0, w0);
        run("m0mid", 0, '0, '0, 1'b1, w0);

        // Abort part-way through the write pass.
        d01 = dcyc1.size(); d02 = dcyc2.size();
        @(posedge clk); #1 mode = 2'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!(cs1 && wr1 && adr1 == 8'd77) && n < 200) begin @(negedge clk); n++; end
        check("abort_reach77", 64'(n < 200), 1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_idle1", 64'({busy1, cs1, wr1}), 0);
        check("abort_idle2", 64'({busy2, cs2, wr2}), 0);
        repeat (600) @(posedge clk);
        check("abort_nodone", 64'((dcyc1.size() - d01) + (dcyc2.size() - d02)), 0);

        @(posedge clk); #1 abort = 1'b1; start = 1'b1;
        @(posedge clk); #1 abort = 1'b0; start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_start_idle", 64'({busy1, cs1, busy2, cs2}), 0);

        for (int r = 0; r < 6; r++) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                fa = $urandom_range(0, 255);
                stuck[fa] = 32'h1 << $urandom_range(0, 31);
            end
            run($sformatf("rnd%0d", r), $urandom_range(0, 3), $urandom,
                ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, 1'b0, w0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
